hilo_divider: RTL and testbench
===============================

// Module: hilo_divider
// PURPOSE
//  Multi-cycle 32-bit integer divider for DIV/DIVU. Sits in the execute stage, directly upstream of the
//  6-input 32-bit writeback select mux: Quotient drives the LO input, Remainder drives the HI input.
//  Uses restoring division, one quotient bit per cycle, with a Start/Busy/Done handshake to the control unit.
//  Also supplies the stall signal: the controller holds the PC while Busy is 1.
// PARAMETERS
//  WIDTH    32                 operand/result width; only 32 is used in the CPU
//  CNT_W    $clog2(WIDTH)+1    iteration counter width
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  Start      in   1      request; sampled only when Busy=0
//  Signed     in   1      1 = DIV (two's complement), 0 = DIVU
//  Dividend   in   WIDTH  rs operand, captured on the accepted Start edge
//  Divisor    in   WIDTH  rt operand, captured on the accepted Start edge
//  Busy       out  1      operation in progress; the controller stalls on it
//  Done       out  1      one-cycle pulse; results valid in this cycle
//  Quotient   out  WIDTH  registered result -> LO
//  Remainder  out  WIDTH  registered result -> HI
// BEHAVIOUR
//  - Reset: state IDLE. Busy=0, Done=0, Quotient=0, Remainder=0, counter=0.
//  - FSM states and transitions:
//    - IDLE -> RUN on Start.
//    - RUN -> FIX after WIDTH iterations.
//    - FIX -> IDLE unconditionally.
//  - Accept (edge E0, in IDLE with Start=1):
//    - latch |Dividend|, |Divisor| when Signed=1, raw values when Signed=0;
//    - latch sign flags qneg = sa^sb and rneg = sa (zero when unsigned);
//    - load partial remainder = 0; Busy=1 from E0.
//  - RUN, one iteration per edge, WIDTH cycles (E1..E32):
//    - shift {rem,quo} left by 1;
//    - trial = rem - divisor in WIDTH+1 bits;
//    - if trial >= 0: rem = trial and the new quotient bit = 1; otherwise the quotient bit = 0.
//  - FIX (E33): negate quo when qneg, negate rem when rneg. Write Quotient/Remainder and set Done=1, Busy=0.
//  - Timing: Done is high for exactly one cycle, after E33. The Start edge to Done takes 33 edges, fixed and data-independent.
//  - Outputs hold their value until the next FIX, or until reset.
//  - Result signs:
//    - the remainder takes the sign of the dividend;
//    - the quotient truncates toward zero;
//    - magnitudes are computed as unsigned, so |0x80000000| = 0x80000000.
//  - Divide by zero (Divisor=0, either mode): same latency. Result is Quotient=32'hFFFFFFFF, Remainder=Dividend (raw input value).
//  - Signed overflow 0x80000000 / 0xFFFFFFFF: Quotient=0x80000000, Remainder=0. No trap.
//  - Start while Busy=1 is ignored. Operands are not re-sampled.
//  - Start on the Done cycle is accepted, because Busy=0 in that cycle. The new operation starts; prior results stay until its FIX.
//  - Reset during RUN/FIX returns the block to IDLE next cycle, clears all outputs, and suppresses Done.
//  - The Signed mode is fixed at Start; changes during RUN have no effect.
// STRUCTURE
//  - Shared header cpu_defs.vh holds:
//    - the FSM encodings DIV_IDLE=2'd0, DIV_RUN=2'd1, DIV_FIX=2'd2;
//    - the divide-by-zero quotient constant 32'hFFFFFFFF.
//  - One combinational sub-module, div_restore_step:
//    - inputs: rem, quo, divisor;
//    - outputs: next_rem, next_quo (one shift and subtract).
//  - Top level holds the FSM, counter, operand/sign registers and sign-fix negation.
// TESTING
//  1 DIVU 100/7, Start at E0 -> Busy high E0..E32; Done pulse after E33; Q=14, R=2.
//  2 DIV 0xFFFFFFF9(-7)/2 -> Q=0xFFFFFFFD(-3), R=0xFFFFFFFF(-1); 7/-2 -> Q=0xFFFFFFFD, R=1.
//  3 DIV/DIVU 0x12345678/0 -> Q=0xFFFFFFFF, R=0x12345678, Done after E33 (same latency).
//  4 DIV 0x80000000/0xFFFFFFFF -> Q=0x80000000, R=0; DIVU of same -> Q=0, R=0x80000000.
//  5 Handshake cases:
//    - start 100/7, then pulse Start with 9/3 at E10 -> ignored; result stays Q=14, R=2;
//    - issue 9/3 on the Done cycle -> accepted, next Done gives Q=3, R=0.
//  6 Reset mid-operation:
//    - assert reset at E15 of 0xFFFF/0x10 -> Busy=0, Q=R=0 next cycle, no Done ever;
//    - a following 10/3 -> Q=3, R=1.

Source files
------------

// File: rtl/hilo_divider_pkg.sv
// Shared definitions for the HI/LO divider: FSM encoding and result constants.
package hilo_divider_pkg;

    localparam int DIV_WIDTH = 32;

    // Divider sequencing states; encodings are fixed so the control unit can decode them.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2
    } divState_e;

    // Quotient returned for any divide by zero, signed or unsigned.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFFFFFF;

endpackage

// File: rtl/hilo_divider_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it is non-negative.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH:0] remShift;
    logic [WIDTH:0] trial;

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value and the trial sign.
    always_comb begin
        remShift = {rem, quo[WIDTH-1]};
        trial    = remShift - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            next_rem = trial[WIDTH-1:0];
            next_quo = {quo[WIDTH-2:0], 1'b1};
        end else begin
            next_rem = remShift[WIDTH-1:0];
            next_quo = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/hilo_divider.sv
// Multi-cycle DIV/DIVU unit feeding LO (Quotient) and HI (Remainder).
// Fixed 33-edge latency from accepted Start to Done; Busy stalls the PC meanwhile.
module hilo_divider
    import hilo_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder
);

    divState_e        state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divisorReg;
    logic             qNeg;
    logic             rNeg;
    logic             divByZero;
    logic [WIDTH-1:0] nextRem;
    logic [WIDTH-1:0] nextQuo;

    div_restore_step #(
        .WIDTH(WIDTH)
    ) stepUnit (
        .rem     (remReg),
        .quo     (quoReg),
        .divisor (divisorReg),
        .next_rem(nextRem),
        .next_quo(nextQuo)
    );

    // Sequencer: capture magnitudes and signs on Start, iterate WIDTH times, then sign-fix and publish.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= DIV_IDLE;
            count      <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            qNeg       <= 1'b0;
            rNeg       <= 1'b0;
            divByZero  <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Quotient   <= '0;
            Remainder  <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (Start) begin
                        remReg     <= '0;
                        quoReg     <= (Signed && Dividend[WIDTH-1]) ? -Dividend : Dividend;
                        divisorReg <= (Signed && Divisor[WIDTH-1]) ? -Divisor : Divisor;
                        qNeg       <= Signed && (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
                        rNeg       <= Signed && Dividend[WIDTH-1];
                        divByZero  <= (Divisor == '0);
                        count      <= '0;
                        Busy       <= 1'b1;
                        state      <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    remReg <= nextRem;
                    quoReg <= nextQuo;
                    count  <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    Quotient  <= divByZero ? DIV_ZERO_QUOTIENT : (qNeg ? -quoReg : quoReg);
                    Remainder <= rNeg ? -remReg : remReg;
                    Done      <= 1'b1;
                    Busy      <= 1'b0;
                    state     <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_divider.sv
// Scoreboard bench for hilo_divider: stimulus pushes expected results from an
// arithmetic reference model, a negedge monitor pops and compares on every Done.
module tb_hilo_divider;

    localparam int LATENCY = 33;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          doneCycle;
    } expect_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic        Signed = 1'b0;
    logic [31:0] Dividend = '0;
    logic [31:0] Divisor = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] Quotient;
    logic [31:0] Remainder;

    int          cycle = 0;
    int          nextFree = 0;
    int          compareCount = 0;
    int          failCount = 0;
    logic [31:0] heldQ = '0;
    logic [31:0] heldR = '0;
    logic [31:0] pendQ = '0;
    logic [31:0] pendR = '0;
    expect_t     sb[$];

    hilo_divider dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .Signed   (Signed),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Busy     (Busy),
        .Done     (Done),
        .Quotient (Quotient),
        .Remainder(Remainder)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used to time expected Done pulses.
    always @(posedge clk) cycle <= cycle + 1;

    // Reference divide from MIPS DIV/DIVU rules using plain arithmetic.
    function automatic void refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                   output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Issue one operation while the model says the divider is idle and record its expectation.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] q;
        logic [31:0] r;
        refDiv(a, b, sgn, q, r);
        Dividend = a;
        Divisor  = b;
        Signed   = sgn;
        Start    = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        sb.push_back('{q: q, r: r, doneCycle: cycle + LATENCY});
        pendQ    = q;
        pendR    = r;
        nextFree = cycle + LATENCY;
    endtask

    // Run until the model expects idle, jostling inputs to prove they are ignored while busy.
    task automatic waitIdle();
        while (cycle < nextFree) begin
            checkOutput("busy_high", {31'd0, Busy}, 32'd1);
            checkOutput("held_quotient", Quotient, heldQ);
            checkOutput("held_remainder", Remainder, heldR);
            Start    = 1'($urandom_range(0, 1));
            Signed   = 1'($urandom_range(0, 1));
            Dividend = $urandom;
            Divisor  = $urandom;
            @(posedge clk);
            #1;
        end
        Start = 1'b0;
        checkOutput("busy_low", {31'd0, Busy}, 32'd0);
        heldQ = pendQ;
        heldR = pendR;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every Done must match the oldest expectation, on time; late ones are flagged.
    always @(negedge clk) begin
        expect_t e;
        if (Done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("quotient", Quotient, e.q);
                checkOutput("remainder", Remainder, e.r);
                checkOutput("done_cycle", 32'(cycle), 32'(e.doneCycle));
            end
        end else if (sb.size() > 0 && cycle > sb[0].doneCycle) begin
            e = sb.pop_front();
            checkOutput("missing_done", 32'd0, 32'd1);
        end
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed cases followed by randomized operations.
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        waitCycles(3);
        reset = 1'b0;
        nextFree = cycle;
        checkOutput("reset_busy", {31'd0, Busy}, 32'd0);
        checkOutput("reset_done", {31'd0, Done}, 32'd0);
        checkOutput("reset_quotient", Quotient, 32'd0);
        checkOutput("reset_remainder", Remainder, 32'd0);

        applyStimulus(32'd100, 32'd7, 1'b0);
        waitIdle();
        applyStimulus(32'hFFFFFFF9, 32'd2, 1'b1);
        waitIdle();
        applyStimulus(32'd7, 32'hFFFFFFFE, 1'b1);
        waitIdle();
        applyStimulus(32'h12345678, 32'd0, 1'b1);
        waitIdle();
        applyStimulus(32'h12345678, 32'd0, 1'b0);
        waitIdle();
        applyStimulus(32'h87654321, 32'd0, 1'b1);
        waitIdle();
        applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1);
        waitIdle();
        applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b0);
        waitIdle();

        applyStimulus(32'd100, 32'd7, 1'b0);
        waitCycles(9);
        Dividend = 32'd9;
        Divisor  = 32'd3;
        Start    = 1'b1;
        waitCycles(1);
        Start = 1'b0;
        waitIdle();
        applyStimulus(32'd9, 32'd3, 1'b0);
        waitIdle();

        applyStimulus(32'h0000FFFF, 32'h10, 1'b0);
        void'(sb.pop_back());
        waitCycles(14);
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        checkOutput("midreset_busy", {31'd0, Busy}, 32'd0);
        checkOutput("midreset_done", {31'd0, Done}, 32'd0);
        checkOutput("midreset_quotient", Quotient, 32'd0);
        checkOutput("midreset_remainder", Remainder, 32'd0);
        heldQ = '0;
        heldR = '0;
        pendQ = '0;
        pendR = '0;
        nextFree = cycle;
        waitCycles(40);
        applyStimulus(32'd10, 32'd3, 1'b0);
        waitIdle();

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                3: b = 32'd0;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            applyStimulus(a, b, 1'($urandom_range(0, 1)));
            waitIdle();
        end

        waitCycles(5);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
